// File: rtl/vector_load_store_unit.sv
// Vector load/store unit: moves one D-element vector between the vector
// register file and DDR, one DDR word (beat) per request.
//   LDV (op_i=0): reads D*BPE words, assembles them, writes one vector register.
//   SV  (op_i=1): snapshots one vector register and writes it out as D*BPE words.
// Address of element e, beat b = base + e*stride + b (wraps modulo 2^DdrAddressWidth),
// generated with a running accumulator.
// Configuration macro LDST_STRIDE_EN: when defined stride_i is honoured, otherwise
// the stride is fixed at BPE (contiguous vectors) and stride_i is ignored.
// Ports:
//   clk_i, rst_i (async, active-high)
//   start_i, op_i, base_addr_i, stride_i, v_addr_i   : command
//   busy_o, done_o                                   : status
//   ddr_req_*                                        : DDR request channel (valid/ready)
//   ddr_rsp_valid_i, ddr_rsp_rdata_i                 : DDR read response
//   vreg_rd_addr_o, vreg_rd_data_i                   : combinational vreg read port
//   vreg_we_o, vreg_wr_addr_o, vreg_wr_data_o        : vreg write port
module vector_load_store_unit #(
    parameter int unsigned D                  = 4,
    parameter int unsigned ElemWidth          = 8,
    parameter int unsigned DdrAddressWidth    = 16,
    parameter int unsigned DdrDataWidth       = 8,
    parameter int unsigned NumVectorRegisters = 4,
    localparam int unsigned VA = (NumVectorRegisters > 1) ? $clog2(NumVectorRegisters) : 1
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       start_i,
    input  logic                       op_i,
    input  logic [DdrAddressWidth-1:0] base_addr_i,
    input  logic [DdrAddressWidth-1:0] stride_i,
    input  logic [VA-1:0]              v_addr_i,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       ddr_req_valid_o,
    input  logic                       ddr_req_ready_i,
    output logic                       ddr_req_we_o,
    output logic [DdrAddressWidth-1:0] ddr_req_addr_o,
    output logic [DdrDataWidth-1:0]    ddr_req_wdata_o,
    input  logic                       ddr_rsp_valid_i,
    input  logic [DdrDataWidth-1:0]    ddr_rsp_rdata_i,
    output logic [VA-1:0]              vreg_rd_addr_o,
    input  logic [D*ElemWidth-1:0]     vreg_rd_data_i,
    output logic                       vreg_we_o,
    output logic [VA-1:0]              vreg_wr_addr_o,
    output logic [D*ElemWidth-1:0]     vreg_wr_data_o
);
    localparam int unsigned BPE = ElemWidth / DdrDataWidth;
    localparam int unsigned NB  = D * BPE;
    localparam int unsigned IW  = (NB > 1) ? $clog2(NB) : 1;
    localparam int unsigned BW  = (BPE > 1) ? $clog2(BPE) : 1;
    localparam int unsigned VW  = D * ElemWidth;
    localparam int unsigned AW  = DdrAddressWidth;

    typedef enum logic [2:0] {StIdle, StReq, StWaitRsp, StWriteback, StDone} state_e;

    state_e          state_q, state_d;
    logic            op_q;
    logic [VA-1:0]   v_addr_q;
    logic [AW-1:0]   elem_base_q;  // base + e*stride for the current element
    logic [BW-1:0]   beat_q;       // beat within the current element
    logic [IW-1:0]   idx_q;        // flat beat index across the whole vector
    logic [VW-1:0]   vec_q;        // store shadow / load assembly buffer
    logic [AW-1:0]   stride_eff;

`ifdef LDST_STRIDE_EN
    logic [AW-1:0] stride_q;
    assign stride_eff = stride_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stride_q <= '0;
        end else if (state_q == StIdle && start_i) begin
            stride_q <= stride_i;
        end
    end
`else
    logic unused_stride;
    assign unused_stride = ^stride_i;
    assign stride_eff    = AW'(BPE);
`endif

    logic          last_beat, elem_end, load_beat, advance;
    logic [AW-1:0] req_addr;

    assign last_beat = (idx_q == IW'(NB - 1));
    assign elem_end  = (beat_q == BW'(BPE - 1));
    assign load_beat = (state_q == StWaitRsp) && ddr_rsp_valid_i;
    // Stores advance on the handshake itself; loads advance when the data returns.
    assign advance   = load_beat || ((state_q == StReq) && op_q && ddr_req_ready_i);
    assign req_addr  = elem_base_q + AW'(beat_q);

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start_i) state_d = StReq;
            end
            StReq: begin
                if (ddr_req_ready_i) begin
                    if (!op_q)         state_d = StWaitRsp;
                    else if (last_beat) state_d = StDone;
                end
            end
            StWaitRsp: begin
                if (ddr_rsp_valid_i) state_d = last_beat ? StWriteback : StReq;
            end
            StWriteback: state_d = StDone;
            StDone:      state_d = StIdle;
            default:     state_d = StIdle;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            op_q        <= 1'b0;
            v_addr_q    <= '0;
            elem_base_q <= '0;
            beat_q      <= '0;
            idx_q       <= '0;
            vec_q       <= '0;
        end else begin
            if (state_q == StIdle && start_i) begin
                op_q        <= op_i;
                v_addr_q    <= v_addr_i;
                elem_base_q <= base_addr_i;
                beat_q      <= '0;
                idx_q       <= '0;
                if (op_i) vec_q <= vreg_rd_data_i;
            end
            if (load_beat) begin
                vec_q[idx_q*DdrDataWidth +: DdrDataWidth] <= ddr_rsp_rdata_i;
            end
            if (advance) begin
                idx_q <= idx_q + 1'b1;
                if (elem_end) begin
                    beat_q      <= '0;
                    elem_base_q <= elem_base_q + stride_eff;
                end else begin
                    beat_q <= beat_q + 1'b1;
                end
            end
        end
    end

    // Outputs
    always_comb begin
        busy_o          = (state_q != StIdle);
        done_o          = (state_q == StDone);
        ddr_req_valid_o = (state_q == StReq);
        ddr_req_we_o    = (state_q == StReq) && op_q;
        ddr_req_addr_o  = (state_q == StReq) ? req_addr : '0;
        ddr_req_wdata_o = '0;
        if ((state_q == StReq) && op_q) begin
            ddr_req_wdata_o = vec_q[idx_q*DdrDataWidth +: DdrDataWidth];
        end
        // Idle exposes the requested register so the SV snapshot is ready at start.
        vreg_rd_addr_o  = rst_i ? '0 : ((state_q == StIdle) ? v_addr_i : v_addr_q);
        vreg_we_o       = (state_q == StWriteback);
        vreg_wr_addr_o  = (state_q == StWriteback) ? v_addr_q : '0;
        vreg_wr_data_o  = (state_q == StWriteback) ? vec_q : '0;
    end

endmodule

// File: doc/vector_load_store_unit.md
VECTOR_LOAD_STORE_UNIT -- requirements
Module: vector_load_store_unit

Interface
REQ-001 Parameter D, default 4: elements per vector.
REQ-002 Parameter ElemWidth, default 8: element width (bits); SHALL be an integer multiple of DdrDataWidth; BPE = ElemWidth/DdrDataWidth beats per element.
REQ-003 Parameter DdrAddressWidth, default 16; parameter DdrDataWidth, default 8; parameter NumVectorRegisters, default 4 (VA = $clog2(NumVectorRegisters)).
REQ-004 One clock, clk_i; reset rst_i is asynchronous and active-high.
REQ-005 clk_i  in  1  clock; rst_i  in  1  async active-high reset.
REQ-006 start_i  in  1  begin operation; op_i  in  1  0=LDV, 1=SV; base_addr_i  in  DdrAddressWidth  first DDR word; stride_i  in  DdrAddressWidth  element stride in DDR words; v_addr_i  in  VA  vector register.
REQ-007 busy_o  out  1  operation in progress; done_o  out  1  one-cycle completion pulse.
REQ-008 ddr_req_valid_o  out  1; ddr_req_ready_i  in  1; ddr_req_we_o  out  1; ddr_req_addr_o  out  DdrAddressWidth; ddr_req_wdata_o  out  DdrDataWidth.
REQ-009 ddr_rsp_valid_i  in  1  read data valid; ddr_rsp_rdata_i  in  DdrDataWidth.
REQ-010 vreg_rd_addr_o  out  VA; vreg_rd_data_i  in  D*ElemWidth  combinational read of vreg_rd_addr_o.
REQ-011 vreg_we_o  out  1; vreg_wr_addr_o  out  VA; vreg_wr_data_o  out  D*ElemWidth; element e occupies bits [e*ElemWidth +: ElemWidth].

Function
REQ-012 FSM states IDLE, REQ, WAIT_RSP, WRITEBACK, DONE; busy_o=1 in every state except IDLE.
REQ-013 IDLE: start_i=1 latches op_i, base_addr_i, stride_i, v_addr_i, clears element/beat counters, enters REQ next cycle; start_i outside IDLE is ignored.
REQ-014 vreg_rd_addr_o SHALL equal v_addr_i in IDLE; on accepted SV start, vreg_rd_data_i is snapshotted into an internal shadow register.
REQ-015 Request address for element e, beat b = base + e*stride + b, modulo 2^DdrAddressWidth (wrap, no error); computed by running accumulator, no multiplier.
REQ-016 REQ: ddr_req_valid_o=1 with addr/we/wdata stable until cycle where ddr_req_ready_i=1 (handshake).
REQ-017 LDV: after handshake go WAIT_RSP; on ddr_rsp_valid_i=1 store rdata into beat b of element e (beat 0 = least-significant bits), advance b then e; return to REQ, or to WRITEBACK after last beat of element D-1.
REQ-018 ddr_rsp_valid_i outside WAIT_RSP SHALL be ignored; at most one read outstanding.
REQ-019 WRITEBACK: vreg_we_o=1 for exactly one cycle with vreg_wr_addr_o=latched v_addr, vreg_wr_data_o=assembled vector; then DONE.
REQ-020 SV: ddr_req_we_o=1, wdata = shadow beat b of element e; after each handshake advance immediately (no response wait); after final beat go DONE.
REQ-021 DONE: done_o=1 for one cycle, then IDLE; start_i in DONE is ignored.
REQ-022 Zero-wait memory (ready=1, rsp one cycle after handshake), D=4, BPE=1: LDV start in cycle 0 -> vreg_we_o cycle 9, done_o cycle 10; SV start cycle 0 -> requests cycles 1-4, done_o cycle 5.
REQ-023 stride_i=0 is legal: every element accesses the same base region.

Reset
REQ-024 rst_i=1 forces IDLE and all outputs to 0 (vreg_rd_addr_o 0, data outputs 0) immediately, independent of clk_i.
REQ-025 Reset mid-operation abandons it: no vreg write, no done_o pulse, outstanding response after reset is ignored.

Configuration
REQ-026 Macro LDST_STRIDE_EN: defined -> stride_i used as in REQ-015; undefined -> stride_i ignored and effective stride fixed at BPE (contiguous vectors).

Verification
REQ-027 LDV, base 0x0010, stride 1, memory[0x10..0x13]=01,02,03,04, ready=1 -> vreg_wr_data_o=0x04030201 to v_addr in cycle 9, done_o cycle 10.
REQ-028 SV, vreg=0xAABBCCDD, base 0xFFFE, stride 1 -> writes DD@FFFE, CC@FFFF, BB@0000, AA@0001 (wrap), done_o cycle 5.
REQ-029 LDV with ready held low 3 cycles per request and rsp delay 2 -> addr/valid stable while stalled, correct vector, exactly one vreg_we_o pulse.
REQ-030 rst_i asserted during second LDV beat -> outputs 0 same cycle, no vreg_we_o/done_o; subsequent SV completes normally.
REQ-031 LDST_STRIDE_EN defined, stride 3, base 0x0100, ElemWidth 16 (BPE 2) -> read addresses 0100,0101,0103,0104,0106,0107,0109,010A; undefined -> 0100..0107.
REQ-032 start_i pulsed while busy and spurious ddr_rsp_valid_i in REQ -> ignored; results match undisturbed run.
